mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 140 ++++++++++++++
 tb/tb_mem_io_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// Memory-mapped I/O responder for a single-cycle core: word RAM, LED/switch
// registers, and a compare-match timer that raises a level interrupt request.
module mem_io_responder #(
  parameter int RAM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  Switches,
  output logic [7:0]  Leds,
  output logic        IrqReq,
  input  logic        IrqAck
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  // Word addresses (Addr[31:2]) of the peripheral registers.
  localparam logic [29:0] W_LED    = 30'h040;
  localparam logic [29:0] W_SW     = 30'h041;
  localparam logic [29:0] W_COUNT  = 30'h042;
  localparam logic [29:0] W_CMP    = 30'h043;
  localparam logic [29:0] W_CTRL   = 30'h044;
  localparam logic [29:0] W_STATUS = 30'h045;

  // Bus protocol: there is no handshake. Every cycle is an access; reads are
  // combinational from Addr, and a write commits on the rising edge where
  // MemWrite=1. The responder never stalls the core.

  logic [29:0] word_addr;
  logic [5:0]  ram_idx;
  logic        ram_sel;
  logic        unused_ok;

  assign word_addr = Addr[31:2];
  assign ram_idx   = Addr[7:2];
  assign ram_sel   = (Addr[31:8] == 24'd0) && (32'(ram_idx) < 32'(RAM_WORDS));
  assign unused_ok = &{1'b0, Addr[1:0]};

  logic we_ram, we_led, we_cmp, we_ctrl, we_status;

  assign we_ram    = MemWrite && ram_sel;
  assign we_led    = MemWrite && (word_addr == W_LED);
  assign we_cmp    = MemWrite && (word_addr == W_CMP);
  assign we_ctrl   = MemWrite && (word_addr == W_CTRL);
  assign we_status = MemWrite && (word_addr == W_STATUS);

  // Data RAM: not reset, contents survive a reset pulse.
  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (we_ram) begin
      mem_q[ram_idx[AW-1:0]] <= WriteData;
    end
  end

  logic [7:0]  leds_q, leds_d;
  logic [7:0]  sync1_q, sync2_q;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pend_q, pend_d;
  logic        ten, ien, match, pend_clr;

  assign ten    = ctrl_q[0];
  assign ien    = ctrl_q[1];
  assign IrqReq = pend_q & ien;
  assign Leds   = leds_q;

  always_comb begin
    leds_d    = leds_q;
    count_d   = count_q;
    compare_d = compare_q;
    ctrl_d    = ctrl_q;
    pend_d    = pend_q;
    match     = ten && (compare_q != 32'd0) && (count_q == compare_q);
    pend_clr  = (IrqAck && IrqReq) || (we_status && WriteData[0]);

    if (ten) begin
      count_d = match ? 32'd0 : count_q + 32'd1;
    end
    if (we_cmp) begin
      compare_d = WriteData;
      count_d   = 32'd0;
    end
    if (we_led) begin
      leds_d = WriteData[7:0];
    end
    if (we_ctrl) begin
      ctrl_d = WriteData[1:0];
    end
    // Set beats clear so a match landing on an ack edge is not lost.
    if (pend_clr) begin
      pend_d = 1'b0;
    end
    if (match) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ctrl_q    <= '0;
      pend_q    <= 1'b0;
    end else begin
      leds_q    <= leds_d;
      sync1_q   <= Switches;
      sync2_q   <= sync1_q;
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (ram_sel) begin
      ReadData = mem_q[ram_idx[AW-1:0]];
    end else begin
      case (word_addr)
        W_LED:    ReadData = {24'd0, leds_q};
        W_SW:     ReadData = {24'd0, sync2_q};
        W_COUNT:  ReadData = count_q;
        W_CMP:    ReadData = compare_q;
        W_CTRL:   ReadData = {30'd0, ctrl_q};
        W_STATUS: ReadData = {31'd0, pend_q};
        default:  ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed address-map, timer,
// interrupt and reset scenarios, then randomized traffic against a reference model.
module tb_mem_io_responder;

  localparam int RW = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  Switches;
  logic [7:0]  Leds;
  logic        IrqReq;
  logic        IrqAck;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  logic [31:0] m_ram [64];
  logic [31:0] m_count, m_compare;
  logic [7:0]  m_leds, m_sw1, m_sw2;
  logic [1:0]  m_ctrl;
  logic        m_pend;

  mem_io_responder #(.RAM_WORDS(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Addr      (Addr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Switches  (Switches),
    .Leds      (Leds),
    .IrqReq    (IrqReq),
    .IrqAck    (IrqAck)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count   = 0;
    m_compare = 0;
    m_leds    = 0;
    m_sw1     = 0;
    m_sw2     = 0;
    m_ctrl    = 0;
    m_pend    = 0;
  endtask

  function automatic logic m_irq();
    return m_pend & m_ctrl[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w < 32'h100) return (w[7:2] < RW) ? m_ram[w[7:2]] : 32'h0;
    case (w)
      32'h100: return {24'h0, m_leds};
      32'h104: return {24'h0, m_sw2};
      32'h108: return m_count;
      32'h10C: return m_compare;
      32'h110: return {30'h0, m_ctrl};
      32'h114: return {31'h0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [31:0] w, nc;
    logic match, clr;
    if (reset) begin
      model_reset();
      return;
    end
    w     = {Addr[31:2], 2'b00};
    match = m_ctrl[0] && (m_compare != 0) && (m_count == m_compare);
    nc    = !m_ctrl[0] ? m_count : (match ? 32'h0 : m_count + 32'h1);
    clr   = (IrqAck && m_irq()) || (MemWrite && w == 32'h114 && WriteData[0]);
    if (clr)   m_pend = 1'b0;
    if (match) m_pend = 1'b1;
    m_sw2 = m_sw1;
    m_sw1 = Switches;
    if (MemWrite) begin
      if (w < 32'h100) begin
        if (w[7:2] < RW) m_ram[w[7:2]] = WriteData;
      end else begin
        case (w)
          32'h100: m_leds = WriteData[7:0];
          32'h10C: begin m_compare = WriteData; nc = 32'h0; end
          32'h110: m_ctrl = WriteData[1:0];
          default: ;
        endcase
      end
    end
    m_count = nc;
  endtask

  // Driver tasks
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Addr      = a;
    WriteData = d;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemWrite = 1'b0;
    Addr     = a;
    #1;
    check_eq(tag, ReadData, exp);
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 3) return 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
    if (r <= 7) return 32'(32'h100 + $urandom_range(0, 5) * 4 + $urandom_range(0, 3));
    if (r == 8) return ($urandom_range(0, 1) == 0) ? 32'h118 : 32'h200;
    return $urandom;
  endfunction

  initial begin
    logic [31:0] cnt_seq [4];
    cnt_seq[0] = 32'd1; cnt_seq[1] = 32'd2; cnt_seq[2] = 32'd3; cnt_seq[3] = 32'd0;

    reset = 1'b1; MemWrite = 1'b0; Addr = '0; WriteData = '0;
    Switches = 8'h00; IrqAck = 1'b0;
    model_reset();
    #2;
    check_eq("rst_leds", {24'h0, Leds}, 32'h0);
    check_eq("rst_irq", {31'h0, IrqReq}, 32'h0);
    check_rd("rst_count", 32'h108, 32'h0);
    check_rd("rst_compare", 32'h10C, 32'h0);
    check_rd("rst_ctrl", 32'h110, 32'h0);
    check_rd("rst_status", 32'h114, 32'h0);
    check_rd("rst_sw", 32'h104, 32'h0);
    repeat (2) tick();
    reset = 1'b0;

    for (int i = 0; i < 64; i++) wr(32'(i * 4), $urandom);

    // RAM and unmapped regions
    wr(32'h3C, 32'hDEADBEEF);
    check_rd("ram_3c", 32'h3C, 32'hDEADBEEF);
    check_rd("ram_3d", 32'h3D, 32'hDEADBEEF);
    check_rd("unmapped_200", 32'h200, 32'h0);
    wr(32'h80, 32'h12345678);
    check_rd("ram_above_words", 32'h80, 32'h0);
    check_rd("ram_top", 32'hFC, 32'h0);
    wr(32'h118, 32'hFFFFFFFF);
    check_rd("unmapped_118", 32'h118, 32'h0);

    // LEDs and read-only registers
    wr(32'h100, 32'h1A5);
    check_eq("leds_out", {24'h0, Leds}, 32'hA5);
    check_rd("leds_rd", 32'h100, 32'hA5);
    wr(32'h104, 32'hFF);
    check_rd("sw_ro", 32'h104, 32'h0);
    wr(32'h108, 32'h55);
    check_rd("count_ro", 32'h108, 32'h0);

    // Timer count sequence, match, ack
    wr(32'h10C, 32'd3);
    wr(32'h110, 32'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_rd("count_seq", 32'h108, cnt_seq[i]);
    end
    check_eq("irq_after_match", {31'h0, IrqReq}, 32'h1);
    check_rd("pend_after_match", 32'h114, 32'h1);
    IrqAck = 1'b1;
    tick();
    IrqAck = 1'b0;
    check_eq("irq_after_ack", {31'h0, IrqReq}, 32'h0);
    check_rd("pend_after_ack", 32'h114, 32'h0);
    wr(32'h110, 32'd0);

    // Ack on the same edge as a new match: set wins
    wr(32'h10C, 32'd1);
    wr(32'h110, 32'd3);
    tick();
    tick();
    check_rd("pend_cmp1", 32'h114, 32'h1);
    tick();
    IrqAck = 1'b1;
    tick();
    IrqAck = 1'b0;
    check_rd("pend_set_wins", 32'h114, 32'h1);
    check_eq("irq_set_wins", {31'h0, IrqReq}, 32'h1);

    // IEN masking, ack without request, status clear
    wr(32'h110, 32'd1);
    check_eq("irq_ien_off", {31'h0, IrqReq}, 32'h0);
    check_rd("pend_ien_off", 32'h114, 32'h1);
    wr(32'h110, 32'd3);
    check_eq("irq_ien_on", {31'h0, IrqReq}, 32'h1);
    wr(32'h110, 32'd0);
    IrqAck = 1'b1;
    tick();
    IrqAck = 1'b0;
    check_rd("ack_no_req", 32'h114, 32'h1);
    wr(32'h114, 32'h0);
    check_rd("status_w0", 32'h114, 32'h1);
    wr(32'h114, 32'h1);
    check_rd("status_w1c", 32'h114, 32'h0);

    // Switch synchronizer latency
    Switches = 8'h5C;
    check_rd("sw_edge0", 32'h104, 32'h0);
    tick();
    check_rd("sw_edge1", 32'h104, 32'h0);
    tick();
    check_rd("sw_edge2", 32'h104, 32'h5C);

    // Asynchronous reset while pending
    wr(32'h100, 32'h3C);
    wr(32'h10C, 32'd2);
    wr(32'h110, 32'd3);
    repeat (4) tick();
    check_eq("irq_before_rst", {31'h0, IrqReq}, 32'h1);
    Addr = 32'h108;
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_async_irq", {31'h0, IrqReq}, 32'h0);
    check_eq("rst_async_leds", {24'h0, Leds}, 32'h0);
    check_rd("rst_async_count", 32'h108, 32'h0);
    model_reset();
    tick();
    reset = 1'b0;
    check_rd("ram_kept", 32'h3C, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("no_irq_after_rst", {31'h0, IrqReq}, 32'h0);
    end

    // Randomized traffic against the model
    wr(32'h10C, 32'd5);
    wr(32'h110, 32'd3);
    for (int n = 0; n < 1500; n++) begin
      Addr      = pick_addr();
      MemWrite  = ($urandom_range(0, 2) == 0);
      WriteData = ({Addr[31:2], 2'b00} == 32'h10C) ? 32'($urandom_range(0, 12)) : $urandom;
      IrqAck    = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) Switches = 8'($urandom);
      #1;
      exp_q.push_back(m_read(Addr));
      check_eq("rand_rd", ReadData, exp_q.pop_front());
      check_eq("rand_irq", {31'h0, IrqReq}, {31'h0, m_irq()});
      check_eq("rand_leds", {24'h0, Leds}, {24'h0, m_leds});
      tick();
    end
    MemWrite = 1'b0;
    IrqAck   = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
